// File: rtl/sfp_row_ctrl_if.sv
// Row streams of the sfp row controller: psum rows in, normalised rows out.
// slave = controller side, master = producer/consumer side.
interface sfp_row_ctrl_if #(
  parameter int col     = 8,
  parameter int bw_psum = 20
);
  logic                     in_valid;
  logic                     in_ready;
  logic [col*bw_psum-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [col*bw_psum-1:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sfp_row_ctrl.sv
// Host-side driver for the absolute-value softmax row: one acc cycle, one div cycle, capture, hand off.
// Optional macro SFP_SIGN_RESTORE_EN re-applies each element's input sign to the normalised result.
module sfp_row_ctrl #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int cnt_w   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sfp_row_ctrl_if.slave          row_if,
  output logic [1:0]             sfp_inst,
  output logic [col*bw_psum-1:0] sfp_in,
  input  logic [col*bw_psum-1:0] sfp_out,
  output logic                   busy,
  output logic [cnt_w-1:0]       row_cnt
);

  localparam int row_w = col*bw_psum;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    DIV  = 3'd2,
    CAP  = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [row_w-1:0]   sfp_in_r, out_data_r, cap_data_s;
  logic [cnt_w-1:0]   row_cnt_r;
  logic               zero_row_r;
  logic [bw_psum-1:0] elem_s;
  logic               in_ready_s, out_valid_s, busy_s, in_fire_s, out_fire_s;
  logic [1:0]         sfp_inst_s;

  assign in_fire_s  = row_if.in_valid & in_ready_s;
  assign out_fire_s = out_valid_s & row_if.out_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: fixed one-cycle ACC/DIV/CAP, OUT waits for the consumer
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (in_fire_s) state_nxt_s = ACC;
        else           state_nxt_s = IDLE;
      end
      ACC: state_nxt_s = DIV;
      DIV: state_nxt_s = CAP;
      CAP: state_nxt_s = OUT;
      OUT: begin
        if (row_if.out_ready) state_nxt_s = IDLE;
        else                  state_nxt_s = OUT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode of the state register; sfp_inst can never be 2'b11
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b1;
    sfp_inst_s  = 2'b00;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
      end
      ACC:     sfp_inst_s  = 2'b10;
      DIV:     sfp_inst_s  = 2'b01;
      CAP:     sfp_inst_s  = 2'b00;
      OUT:     out_valid_s = 1'b1;
      default: begin
        in_ready_s = 1'b0;
        busy_s     = 1'b1;
      end
    endcase
  end

  // Row latch, result capture and completed-row counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sfp_in_r   <= {row_w{1'b0}};
      zero_row_r <= 1'b0;
      out_data_r <= {row_w{1'b0}};
      row_cnt_r  <= {cnt_w{1'b0}};
    end else begin
      if (in_fire_s) begin
        sfp_in_r   <= row_if.in_data;
        zero_row_r <= (row_if.in_data == {row_w{1'b0}});
      end
      if (state_r == CAP) out_data_r <= cap_data_s;
      if (out_fire_s)     row_cnt_r  <= row_cnt_r + {{(cnt_w-1){1'b0}}, 1'b1};
    end
  end

`ifdef SFP_SIGN_RESTORE_EN
  logic [col-1:0] sign_r;

  // Per-element input sign, needed to re-sign the magnitude result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_r <= {col{1'b0}};
    end else if (in_fire_s) begin
      for (int i = 0; i < col; i++) sign_r[i] <= row_if.in_data[i*bw_psum + bw_psum - 1];
    end else begin
      sign_r <= sign_r;
    end
  end
`endif

  // Captured value: zero rows are masked to hide the sfp row's divide-by-zero output
  always_comb begin
    cap_data_s = {row_w{1'b0}};
    elem_s     = {bw_psum{1'b0}};
    for (int i = 0; i < col; i++) begin
      elem_s = sfp_out[i*bw_psum +: bw_psum];
      if (zero_row_r) begin
        cap_data_s[i*bw_psum +: bw_psum] = {bw_psum{1'b0}};
      end else begin
`ifdef SFP_SIGN_RESTORE_EN
        if (sign_r[i]) cap_data_s[i*bw_psum +: bw_psum] = ~elem_s + {{(bw_psum-1){1'b0}}, 1'b1};
        else           cap_data_s[i*bw_psum +: bw_psum] = elem_s;
`else
        cap_data_s[i*bw_psum +: bw_psum] = elem_s;
`endif
      end
    end
  end

  assign row_if.in_ready  = in_ready_s;
  assign row_if.out_valid = out_valid_s;
  assign row_if.out_data  = out_data_r;
  assign sfp_inst         = sfp_inst_s;
  assign sfp_in           = sfp_in_r;
  assign busy             = busy_s;
  assign row_cnt          = row_cnt_r;

endmodule
